// File: rtl/seq_chunk_adder_if.sv
// rtl/seq_chunk_adder_if.sv - operand/result handshake bundle for seq_chunk_adder
interface seq_chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - chunk-serial add/subtract with registered inter-chunk carry
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    seq_chunk_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   chunk_sum;
    logic             c_msb;

    always_comb begin
        a_ch      = a_q[int'(cnt_q) * CHUNK +: CHUNK];
        b_ch      = b_q[int'(cnt_q) * CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the chunk's top bit, recovered from its sum bit and operands.
        c_msb     = chunk_sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ^ bus.cin;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                s_d[int'(cnt_q) * CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = c_msb ^ chunk_sum[CHUNK];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - directed self-checking bench for seq_chunk_adder
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(32)) b32 ();
    seq_chunk_adder_if #(.WIDTH(16)) b16 ();

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8))  dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(b32));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(b16));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        v;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and waits for out_valid; lat = -1 on timeout.
    task automatic run_op(input bit w16, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input bit keep_valid,
                          output logic [31:0] s, output logic cout, output logic ovf,
                          output int lat);
        int  n;
        logic ov;
        if (w16) begin
            b16.in_valid = 1'b1; b16.a = a[15:0]; b16.b = b[15:0]; b16.cin = cin; b16.sub = sub;
        end else begin
            b32.in_valid = 1'b1; b32.a = a; b32.b = b; b32.cin = cin; b32.sub = sub;
        end
        n = 0;
        while (!(w16 ? b16.in_ready : b32.in_ready) && n < 20) begin
            step();
            n++;
        end
        step();
        if (w16) begin
            b16.in_valid = keep_valid; b16.a = ~a[15:0]; b16.b = ~b[15:0]; b16.cin = ~cin; b16.sub = ~sub;
        end else begin
            b32.in_valid = keep_valid; b32.a = ~a; b32.b = ~b; b32.cin = ~cin; b32.sub = ~sub;
        end
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 20) begin
            step();
            lat++;
            ov = w16 ? b16.out_valid : b32.out_valid;
        end
        if (!ov) lat = -1;
        s    = w16 ? {16'h0, b16.s} : b32.s;
        cout = w16 ? b16.cout : b32.cout;
        ovf  = w16 ? b16.ovf : b32.ovf;
    endtask

    task automatic test_reset();
        logic [31:0] s; logic c, v; int lat;
        b32.out_ready = 1'b0;
        run_op(1'b0, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 1'b0, s, c, v, lat);
        @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", b32.out_valid); end
        checks++; if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", b32.in_ready); end
        checks++; if (b32.s !== 32'h0) begin errors++; $display("FAIL reset_s: got %h expected 00000000", b32.s); end
        checks++; if (b32.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", b32.cout); end
        checks++; if (b32.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", b32.ovf); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_add();
        logic [31:0] s; logic c, v; int lat;
        b32.out_ready = 1'b1;
        run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, s, c, v, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        checks++; if (s !== 32'h0000_0100) begin errors++; $display("FAIL basic_s: got %h expected 00000100", s); end
        checks++; if ({c, v} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {c, v}); end
        checks++; if (b32.in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done: got %b expected 0", b32.in_ready); end
        step();
        checks++; if ({b32.in_ready, b32.out_valid} !== 2'b10) begin errors++; $display("FAIL basic_back_to_idle: got %b expected 10", {b32.in_ready, b32.out_valid}); end
    endtask

    task automatic test_arith(input bit w16);
        vec_t tv[6];
        logic [31:0] s; logic c, v; int lat;
        if (w16) begin
            tv[0] = '{32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0};
            tv[1] = '{32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0};
            tv[2] = '{32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1};
            tv[3] = '{32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0};
            tv[4] = '{32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1};
            tv[5] = '{32'h000A, 32'h0003, 1'b1, 1'b1, 32'h0006, 1'b1, 1'b0};
        end else begin
            tv[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
            tv[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
            tv[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
            tv[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
            tv[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
            tv[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
        end
        b32.out_ready = 1'b1;
        b16.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(w16, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, 1'b0, s, c, v, lat);
            checks++; if (lat !== (w16 ? 1 : 4)) begin errors++; $display("FAIL arith_latency w16=%0d vec%0d: got %0d expected %0d", w16, i, lat, w16 ? 1 : 4); end
            checks++; if (s !== tv[i].s) begin errors++; $display("FAIL arith_s w16=%0d vec%0d: got %h expected %h", w16, i, s, tv[i].s); end
            checks++; if ({c, v} !== {tv[i].c, tv[i].v}) begin errors++; $display("FAIL arith_flags w16=%0d vec%0d: got %b expected %b", w16, i, {c, v}, {tv[i].c, tv[i].v}); end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s; logic c, v; int lat;
        b32.out_ready = 1'b0;
        run_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, s, c, v, lat);
        checks++; if (s !== 32'h2345_6789 || {c, v} !== 2'b00) begin errors++; $display("FAIL bp_result: got %h/%b expected 23456789/00", s, {c, v}); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0 || b32.s !== 32'h2345_6789 || {b32.cout, b32.ovf} !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold cycle%0d: got v=%b r=%b s=%h f=%b expected v=1 r=0 s=23456789 f=00",
                         i, b32.out_valid, b32.in_ready, b32.s, {b32.cout, b32.ovf});
            end
        end
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        step();
        checks++; if ({b32.in_ready, b32.out_valid} !== 2'b10) begin errors++; $display("FAIL bp_release: got %b expected 10", {b32.in_ready, b32.out_valid}); end
        checks++; if (b32.s !== 32'h2345_6789) begin errors++; $display("FAIL bp_s_kept: got %h expected 23456789", b32.s); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] s; logic c, v; int lat;
        bit seen;
        b32.out_ready = 1'b1;
        b32.in_valid = 1'b1; b32.a = 32'h0000_00FF; b32.b = 32'h1; b32.cin = 1'b0; b32.sub = 1'b0;
        step();
        b32.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0 || b32.s !== 32'h0 || {b32.cout, b32.ovf} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_outputs: got r=%b v=%b s=%h f=%b expected r=1 v=0 s=00000000 f=00",
                     b32.in_ready, b32.out_valid, b32.s, {b32.cout, b32.ovf});
        end
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (b32.out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_result: got out_valid=1 expected 0"); end
        run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, s, c, v, lat);
        checks++; if (lat !== 4 || s !== 32'h0000_0100 || {c, v} !== 2'b00) begin errors++; $display("FAIL midreset_rerun: got lat=%0d s=%h f=%b expected lat=4 s=00000100 f=00", lat, s, {c, v}); end
        step();
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.cin = 1'b0; b32.sub = 1'b0; b32.out_ready = 1'b0;
        b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.sub = 1'b0; b16.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_basic_add();
        test_arith(1'b0);
        test_backpressure();
        test_reset_mid_op();
        test_arith(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
